// File: rtl/rs_ldst_sched.sv
// In-order allocate/issue scheduler for the load/store reservation station (ring of entries).
// Optional full-stall cycle counter enabled by defining RS_LDST_SCHED_PERF_EN.
module rs_ldst_sched #(
    parameter int ENT_NUM = 2,
    parameter int ENT_SEL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_dp_req_1,
    input  logic               i_dp_req_2,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [ENT_NUM-1:0] i_busy_vec,
    input  logic [ENT_NUM-1:0] i_vld_vec,
    input  logic               i_ex_ldst_rdy,
    output logic               o_alloc_vld_1,
    output logic [ENT_SEL-1:0] o_alloc_sel_1,
    output logic               o_alloc_vld_2,
    output logic [ENT_SEL-1:0] o_alloc_sel_2,
    output logic               o_stall_full,
    output logic               o_is_vld,
    output logic [ENT_SEL-1:0] o_is_sel,
    output logic [31:0]        o_perf_full_cyc
);
    localparam int CNT_W = ENT_SEL + 1;

    logic [ENT_SEL-1:0] r_head;
    logic [ENT_SEL-1:0] r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [CNT_W-1:0]   w_nreq;
    logic [CNT_W-1:0]   w_free;
    logic [CNT_W-1:0]   w_nalloc;
    logic [CNT_W-1:0]   w_nissue;
    logic [ENT_SEL-1:0] w_sel_2;
    logic [ENT_SEL-1:0] w_tail_adv;
    logic               w_alloc;

    // Ring increment by explicit compare so ENT_NUM need not be a power of two.
    function automatic logic [ENT_SEL-1:0] f_wrap_inc(input logic [ENT_SEL-1:0] idx);
        if (idx == ENT_SEL'(ENT_NUM - 1)) begin
            f_wrap_inc = {ENT_SEL{1'b0}};
        end else begin
            f_wrap_inc = idx + ENT_SEL'(1);
        end
    endfunction

    assign w_nreq     = {{(CNT_W-1){1'b0}}, i_dp_req_1} + {{(CNT_W-1){1'b0}}, i_dp_req_2};
    assign w_free     = CNT_W'(ENT_NUM) - r_count;
    assign w_sel_2    = i_dp_req_1 ? f_wrap_inc(r_tail) : r_tail;
    assign w_tail_adv = i_dp_req_2 ? f_wrap_inc(w_sel_2) : w_sel_2;

    // A same-cycle issue deliberately does not free a slot for allocation.
    assign o_stall_full  = (w_free < w_nreq);
    assign w_alloc       = !i_stall && !o_stall_full && !i_flush;
    assign o_alloc_vld_1 = i_dp_req_1;
    assign o_alloc_vld_2 = i_dp_req_2;
    assign o_alloc_sel_1 = r_tail;
    assign o_alloc_sel_2 = w_sel_2;

    assign o_is_vld = (r_count != {CNT_W{1'b0}}) && i_vld_vec[r_head] && i_ex_ldst_rdy && !i_flush;
    assign o_is_sel = r_head;

    assign w_nalloc = w_alloc ? w_nreq : {CNT_W{1'b0}};
    assign w_nissue = {{(CNT_W-1){1'b0}}, o_is_vld};

    // Ring pointers and occupancy; flush empties the ring on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= {ENT_SEL{1'b0}};
            r_tail  <= {ENT_SEL{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            r_head  <= {ENT_SEL{1'b0}};
            r_tail  <= {ENT_SEL{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_alloc) begin
                r_tail <= w_tail_adv;
            end else begin
                r_tail <= r_tail;
            end
            if (o_is_vld) begin
                r_head <= f_wrap_inc(r_head);
            end else begin
                r_head <= r_head;
            end
            r_count <= r_count + w_nalloc - w_nissue;
        end
    end

`ifdef RS_LDST_SCHED_PERF_EN
    logic [31:0] r_perf_full_cyc;

    // Saturating count of cycles where a request was blocked by a full ring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_full_cyc <= 32'h0000_0000;
        end else if (o_stall_full && (w_nreq != {CNT_W{1'b0}}) && (r_perf_full_cyc != 32'hFFFF_FFFF)) begin
            r_perf_full_cyc <= r_perf_full_cyc + 32'h0000_0001;
        end else begin
            r_perf_full_cyc <= r_perf_full_cyc;
        end
    end

    assign o_perf_full_cyc = r_perf_full_cyc;
`else
    assign o_perf_full_cyc = 32'h0000_0000;
`endif

`ifndef SYNTHESIS
    // An occupied ring must have a busy entry at its head.
    always_ff @(posedge clk) begin
        if (rst_n && (r_count != {CNT_W{1'b0}}) && !i_busy_vec[r_head]) begin
            $error("rs_ldst_sched: head entry %0d not busy while count=%0d", r_head, r_count);
        end
    end
`endif
endmodule

// File: tb/tb_rs_ldst_sched.sv
// Directed bench for rs_ldst_sched: ENT_NUM=2 main instance plus an ENT_NUM=3 instance for wrap checks.
module tb_rs_ldst_sched;
    logic        clk;
    logic        rst_n;
    logic        i_dp_req_1, i_dp_req_2, i_stall, i_flush, i_ex_ldst_rdy;
    logic [1:0]  busy2, vld2;
    logic [2:0]  busy3, vld3;

    logic        a_vld1_2, a_vld2_2, stall_2, is_vld_2;
    logic        sel1_2, sel2_2, is_sel_2;
    logic [31:0] perf_2;
    logic        a_vld1_3, a_vld2_3, stall_3, is_vld_3;
    logic [1:0]  sel1_3, sel2_3, is_sel_3;
    logic [31:0] perf_3;

    int n_checks = 0;
    int n_errors = 0;

    rs_ldst_sched #(.ENT_NUM(2), .ENT_SEL(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_dp_req_1(i_dp_req_1), .i_dp_req_2(i_dp_req_2),
        .i_stall(i_stall), .i_flush(i_flush),
        .i_busy_vec(busy2), .i_vld_vec(vld2), .i_ex_ldst_rdy(i_ex_ldst_rdy),
        .o_alloc_vld_1(a_vld1_2), .o_alloc_sel_1(sel1_2),
        .o_alloc_vld_2(a_vld2_2), .o_alloc_sel_2(sel2_2),
        .o_stall_full(stall_2), .o_is_vld(is_vld_2), .o_is_sel(is_sel_2),
        .o_perf_full_cyc(perf_2)
    );

    rs_ldst_sched #(.ENT_NUM(3), .ENT_SEL(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_dp_req_1(i_dp_req_1), .i_dp_req_2(i_dp_req_2),
        .i_stall(i_stall), .i_flush(i_flush),
        .i_busy_vec(busy3), .i_vld_vec(vld3), .i_ex_ldst_rdy(i_ex_ldst_rdy),
        .o_alloc_vld_1(a_vld1_3), .o_alloc_sel_1(sel1_3),
        .o_alloc_vld_2(a_vld2_3), .o_alloc_sel_2(sel2_3),
        .o_stall_full(stall_3), .o_is_vld(is_vld_3), .o_is_sel(is_sel_3),
        .o_perf_full_cyc(perf_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r1, input logic r2, input logic st, input logic fl,
                          input logic rdy, input logic [1:0] v2, input logic [2:0] v3);
        i_dp_req_1    = r1;
        i_dp_req_2    = r2;
        i_stall       = st;
        i_flush       = fl;
        i_ex_ldst_rdy = rdy;
        vld2          = v2;
        vld3          = v3;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    logic [31:0] exp_perf;

    initial begin
        busy2 = 2'b11;
        busy3 = 3'b111;
        do_reset();
        check_val("rst_is_vld", 32'(is_vld_2), 32'd0);
        check_val("rst_stall", 32'(stall_2), 32'd0);
        check_val("rst_perf", perf_2, 32'd0);

        // Test 1: dual alloc from reset; external stall blocks commit
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000);
        check_val("t1_sel1", 32'(sel1_2), 32'd0);
        check_val("t1_sel2", 32'(sel2_2), 32'd1);
        check_val("t1_avld2", 32'(a_vld2_2), 32'd1);
        check_val("t1_nostall", 32'(stall_2), 32'd0);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        check_val("t1_stall_blocked", 32'(stall_2), 32'd0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        // Test 2: full ring
        check_val("t2_full_stall", 32'(stall_2), 32'd1);
        check_val("t2_tail0", 32'(sel1_2), 32'd0);
        tick();
        check_val("t2_still_full", 32'(stall_2), 32'd1);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000);
        check_val("t2_issue_vld", 32'(is_vld_2), 32'd1);
        check_val("t2_issue_sel", 32'(is_sel_2), 32'd0);
        check_val("t2_issue_nofree", 32'(stall_2), 32'd1);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        check_val("t2_after_nostall", 32'(stall_2), 32'd0);
        check_val("t2_after_sel", 32'(sel1_2), 32'd0);
        tick();
        check_val("t2_refull", 32'(stall_2), 32'd1);
        check_val("t2_tail1", 32'(sel1_2), 32'd1);

        // Test 3: in-order issue
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000);
        check_val("t3_inorder_block", 32'(is_vld_2), 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000);
        check_val("t3_exrdy_block", 32'(is_vld_2), 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b000);
        check_val("t3_is_vld0", 32'(is_vld_2), 32'd1);
        check_val("t3_is_sel0", 32'(is_sel_2), 32'd0);
        tick();
        check_val("t3_is_vld1", 32'(is_vld_2), 32'd1);
        check_val("t3_is_sel1", 32'(is_sel_2), 32'd1);
        tick();
        check_val("t3_empty_stale", 32'(is_vld_2), 32'd0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        check_val("t3_empty_nostall", 32'(stall_2), 32'd0);
        check_val("t3_empty_sel1", 32'(sel1_2), 32'd0);

        // Test 4: ENT_NUM=3 wrap (tail=2, count=1)
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001);
        check_val("t4_issue", 32'(is_vld_3), 32'd1);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        check_val("t4_sel1", 32'(sel1_3), 32'd2);
        check_val("t4_sel2", 32'(sel2_3), 32'd0);
        check_val("t4_nostall", 32'(stall_3), 32'd0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        check_val("t4_full", 32'(stall_3), 32'd1);
        check_val("t4_tail1", 32'(sel1_3), 32'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010);
        check_val("t4_head1", 32'(is_sel_3), 32'd1);

        // Test 5: flush with nonzero head/tail
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 3'b000);
        check_val("t5_flush_noissue", 32'(is_vld_2), 32'd0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b000);
        check_val("t5_count0", 32'(is_vld_2), 32'd0);
        check_val("t5_head0", 32'(is_sel_2), 32'd0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        check_val("t5_nostall", 32'(stall_2), 32'd0);
        check_val("t5_tail0", 32'(sel1_2), 32'd0);

        // Test 6: full-stall performance counter
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        tick();
`ifdef RS_LDST_SCHED_PERF_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        check_val("t6_perf", perf_2, exp_perf);
        check_val("t6_perf_flush_keep_setup", 32'(stall_2), 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        check_val("t6_perf_after_flush", perf_2, exp_perf);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
